alu_addsub_pipe: RTL and testbench

- Parametrised, pipelined successor of the shared 32-bit add/sub unit with signed overflow flags.
- Splits the WIDTH-bit carry chain into STAGES slices, one slice per pipeline stage, to shorten the critical path.
- Adds a valid/ready handshake with backpressure, optional signed saturation, carry/zero flags and a sticky overflow register.
- Sits between operand select and writeback in the multi-cycle/pipelined datapath.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/addsub_slice.sv | 14 +
 rtl/alu_addsub_pipe.sv | 137 +++++++++++++
 tb/tb_alu_addsub_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encodings and saturation limits for the add/sub pipeline
package alu_pkg;

  localparam logic [1:0] OP_SUB  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUBS = 2'b10;
  localparam logic [1:0] OP_ADDS = 2'b11;

  localparam int MAX_W = 64;

  // Callers truncate the result to their own width.
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - one combinational slice of the split carry chain
module addsub_slice #(
  parameter int SW = 16
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

endmodule

// File: rtl/alu_addsub_pipe.sv
// rtl/alu_addsub_pipe.sv - pipelined add/sub with saturation, flags and sticky overflow
module alu_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             pos_ovf,
  output logic             neg_ovf,
  output logic             carry,
  output logic             zero,
  input  logic             clr_sticky,
  output logic             sticky_ovf
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  localparam logic [MAX_W-1:0] SMAX_F = sat_max(WIDTH);
  localparam logic [MAX_W-1:0] SMIN_F = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SMAX = SMAX_F[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN = SMIN_F[WIDTH-1:0];
  localparam bit SAT_ON = (SAT_EN != 0);

  logic [STAGES-1:0] v_q, adv, load;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic              c_q [STAGES];
  logic              sat_q [STAGES];

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_r [STAGES];
  logic [WIDTH-1:0]  nxt_r [STAGES];
  logic              src_c [STAGES];
  logic              src_sat [STAGES];
  logic [SW-1:0]     sum_s [STAGES];
  logic              cout_s [STAGES];

  logic is_sub, is_sat, room, xfer;

  assign is_sub = (op == OP_SUB) || (op == OP_SUBS);
  assign is_sat = (op == OP_SUBS) || (op == OP_ADDS);

  // b is stored pre-inverted for subtraction, so later stages never look at op.
  always_comb begin
    src_a[0]   = a;
    src_b[0]   = is_sub ? ~b : b;
    src_r[0]   = '0;
    src_c[0]   = is_sub;
    src_sat[0] = is_sat;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_r[k]   = r_q[k-1];
      src_c[k]   = c_q[k-1];
      src_sat[k] = sat_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    addsub_slice #(.SW(SW)) u_slice (
      .a    (src_a[k][k*SW +: SW]),
      .b    (src_b[k][k*SW +: SW]),
      .cin  (src_c[k]),
      .sum  (sum_s[k]),
      .cout (cout_s[k])
    );
    assign nxt_r[k] = src_r[k] | (WIDTH'(sum_s[k]) << (k * SW));
  end

  // A stage moves when any later stage is empty or the consumer takes the result.
  always_comb begin
    adv  = '0;
    load = '0;
    room = out_ready;
    for (int k = L; k >= 0; k--) begin
      adv[k] = v_q[k] & room;
      room   = room | ~v_q[k];
    end
    load[0] = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) load[k] = adv[k-1];
  end

  assign in_ready = ~v_q[0] | adv[0];
  assign xfer     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q        <= '0;
      sticky_ovf <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sat_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k]   <= 1'b1;
          a_q[k]   <= src_a[k];
          b_q[k]   <= src_b[k];
          r_q[k]   <= nxt_r[k];
          c_q[k]   <= cout_s[k];
          sat_q[k] <= src_sat[k];
        end else if (adv[k]) begin
          v_q[k] <= 1'b0;
        end
      end
      if (xfer && (pos_ovf || neg_ovf)) sticky_ovf <= 1'b1;
      else if (clr_sticky)               sticky_ovf <= 1'b0;
    end
  end

  // With b pre-inverted, ADD and SUB share one overflow rule on the sign bits.
  assign pos_ovf   = ~a_q[L][WIDTH-1] & ~b_q[L][WIDTH-1] &  r_q[L][WIDTH-1];
  assign neg_ovf   =  a_q[L][WIDTH-1] &  b_q[L][WIDTH-1] & ~r_q[L][WIDTH-1];
  assign y         = (SAT_ON & sat_q[L] & pos_ovf) ? SMAX :
                     (SAT_ON & sat_q[L] & neg_ovf) ? SMIN : r_q[L];
  assign carry     = c_q[L];
  assign out_valid = v_q[L];
  assign zero      = v_q[L] & (y == '0);

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// tb/tb_alu_addsub_pipe.sv - scoreboard bench over three width/depth configurations
module tb_alu_addsub_pipe;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] y;
    logic        pos, neg, carry, zero;
    int          acc;
    bit          lat;
  } ent_t;

  int   total = 0;
  int   bad   = 0;
  logic clk   = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input int cfg, input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL cfg%0d %s: got=%0h want=%0h", cfg, nm, got, want);
    end
  endtask

  // Reference: exact signed integer arithmetic, then clamp or wrap.
  function automatic ent_t model(input int w, input logic [1:0] o, input logic [63:0] x, input logic [63:0] z);
    longint ua, ub, sa, sb, res, lim;
    ent_t   e;
    ua  = longint'(x);
    ub  = longint'(z);
    lim = longint'(1) << (w - 1);
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sb  = (ub >= lim) ? ub - 2 * lim : ub;
    res = o[0] ? sa + sb : sa - sb;
    e.pos   = (res > lim - 1);
    e.neg   = (res < -lim);
    e.carry = o[0] ? (ua + ub >= 2 * lim) : (ua >= ub);
    if (o[1] && e.pos)      res = lim - 1;
    else if (o[1] && e.neg) res = -lim;
    e.y    = 64'(res) & 64'(2 * lim - 1);
    e.zero = (e.y == 64'd0);
    e.acc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W = (g == 1) ? 16 : 32;
    localparam int S = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

    logic rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, clr_sticky = 1'b0;
    logic in_ready, out_valid, pos_ovf, neg_ovf, carry, zero, sticky_ovf;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0, y;
    ent_t q[$];
    int   cyc  = 0;
    bit   done = 1'b0;

    alu_addsub_pipe #(.WIDTH(W), .STAGES(S), .SAT_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .pos_ovf(pos_ovf), .neg_ovf(neg_ovf), .carry(carry), .zero(zero),
      .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input bit lat);
      ent_t e;
      e     = model(W, op, 64'(a), 64'(b));
      e.acc = cyc;
      e.lat = lat;
      q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
      int w = 0;
      in_valid = 1'b1; op = o; a = x; b = z;
      #1;
      while (!in_ready && w < 100) begin
        @(negedge clk); #1; w++;
      end
      if (in_ready) push_exp(1'b1);
      else chk(g, "issue_timeout", 64'd0, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
    endtask

    task automatic stream(input int n, input int st, input int sl);
      int sent = 0;
      int c    = 0;
      while (sent < n && c < n + sl + 20) begin
        out_ready = !(c >= st && c < st + sl);
        in_valid = 1'b1; op = OP_ADD; a = W'(sent); b = W'(1);
        #1;
        chk(g, out_ready ? "flow_in_ready" : "full_in_ready", 64'(in_ready), 64'(out_ready));
        if (in_ready) begin
          push_exp(sl == 0);
          sent++;
        end
        c++;
        @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk(g, "stream_cycles", 64'(c), 64'(n + sl));
    endtask

    function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
        0: return '0;
        1: return MAXP;
        2: return MINN;
        3: return '1;
        4: return W'(1);
        default: return W'($urandom);
      endcase
    endfunction

    initial begin : drive
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(OP_ADD, MAXP, W'(1));   idle(S + 1);
      issue(OP_ADDS, MAXP, W'(1));  idle(S + 1);
      clr_sticky = 1'b1; @(negedge clk); clr_sticky = 1'b0; idle(1);
      issue(OP_SUBS, MINN, W'(1));
      issue(OP_SUB, W'(5), W'(5));
      issue(OP_SUB, W'(3), W'(5));  idle(S + 1);
      stream(8, 0, 0);              idle(S + 1);
      stream(12, 5, 3);             idle(S + 2);
      // Reset with operations still in flight.
      issue(OP_ADDS, MAXP, W'(1));  idle(S + 1);
      issue(OP_ADD, W'(10), W'(20));
      issue(OP_ADD, W'(30), W'(40));
      rst_n = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      issue(OP_ADD, W'(1), W'(2));  idle(S + 1);
      for (int i = 0; i < 300; i++) begin
        out_ready  = ($urandom_range(0, 9) < 7);
        clr_sticky = ($urandom_range(0, 11) == 0);
        in_valid   = ($urandom_range(0, 9) < 7);
        op = 2'($urandom);
        a  = pick();
        b  = pick();
        #1;
        if (in_valid && in_ready) push_exp(1'b0);
        @(negedge clk);
      end
      in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
      chk(g, "drained", 64'(q.size()), 64'd0);
      idle(2);
      done = 1'b1;
    end

    initial begin : monitor
      ent_t         e;
      bit           set;
      bit           hold = 1'b0, m_sticky = 1'b0, prev_rst = 1'b0;
      logic [W-1:0] hold_y = '0;
      forever begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
          q.delete();
          m_sticky = 1'b0;
          hold     = 1'b0;
          prev_rst = 1'b1;
        end else begin
          if (prev_rst) begin
            chk(g, "rst_out_valid", 64'(out_valid), 64'd0);
            chk(g, "rst_y",         64'(y),         64'd0);
            chk(g, "rst_pos_ovf",   64'(pos_ovf),   64'd0);
            chk(g, "rst_neg_ovf",   64'(neg_ovf),   64'd0);
            chk(g, "rst_carry",     64'(carry),     64'd0);
            chk(g, "rst_zero",      64'(zero),      64'd0);
            chk(g, "rst_in_ready",  64'(in_ready),  64'd1);
            prev_rst = 1'b0;
          end
          if (hold) begin
            chk(g, "hold_valid", 64'(out_valid), 64'd1);
            chk(g, "hold_y",     64'(y),         64'(hold_y));
          end
          chk(g, "sticky_ovf", 64'(sticky_ovf), 64'(m_sticky));
          set = 1'b0;
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              chk(g, "spurious_out", 64'd1, 64'd0);
            end else begin
              e = q.pop_front();
              chk(g, "y",       64'(y),       e.y);
              chk(g, "pos_ovf", 64'(pos_ovf), 64'(e.pos));
              chk(g, "neg_ovf", 64'(neg_ovf), 64'(e.neg));
              chk(g, "carry",   64'(carry),   64'(e.carry));
              chk(g, "zero",    64'(zero),    64'(e.zero));
              if (e.lat) chk(g, "latency", 64'(cyc - e.acc), 64'(S));
              set = e.pos | e.neg;
            end
          end
          if (set)             m_sticky = 1'b1;
          else if (clr_sticky) m_sticky = 1'b0;
          hold   = out_valid && !out_ready;
          hold_y = y;
        end
      end
    end
  end

  initial begin
    for (int t = 0; t < 20000; t++) begin
      @(posedge clk);
      if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
    end
    if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done)) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got=not_done want=done");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
